mem_bus_interface: RTL and testbench
====================================

MEM_BUS_INTERFACE -- requirements
Module: mem_bus_interface

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the memory word-address width (512 words).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of request cycles before an access aborts.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 BusMuxOut  input  32  current CPU bus value.
REQ-006 MARin  input  1  load MAR from BusMuxOut.
REQ-007 MDRin  input  1  load MDR from BusMuxOut.
REQ-008 Read  input  1  start a memory read into MDR.
REQ-009 Write  input  1  start a memory write of MDR.
REQ-010 mem_rdata  input  32  memory read data.
REQ-011 mem_ack  input  1  memory completion strobe.
REQ-012 mem_addr  output  ADDR_W  MAR[ADDR_W-1:0].
REQ-013 mem_wdata  output  32  MDR contents.
REQ-014 mem_req  output  1  access in progress.
REQ-015 mem_we  output  1  write qualifier, valid while mem_req is high.
REQ-016 BusMuxIn_MDR  output  32  MDR value, fed to the bus multiplexer.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE and ERR.
REQ-021 IDLE with Read=1 SHALL move to REQ with mem_we=0 next cycle; Read=1 and Write=1 together SHALL start a read (read has priority).
REQ-022 IDLE with Write=1 and Read=0 SHALL move to REQ with mem_we=1.
REQ-023 A start (Read or Write) SHALL clear err and load the timeout counter with 0.
REQ-024 In REQ, mem_req SHALL be 1 and the counter SHALL increment each cycle mem_ack=0.
REQ-025 In REQ with mem_ack=1: a read SHALL capture mem_rdata into MDR at that edge; either access SHALL then go to DONE.
REQ-026 In REQ with mem_ack=0 and counter=TIMEOUT-1, the FSM SHALL go to ERR; MDR SHALL be unchanged.
REQ-027 If mem_ack=1 arrives on the timeout cycle, ack SHALL win.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-029 ERR SHALL set err, deassert mem_req, and return to IDLE next cycle; err SHALL hold until the next start or reset.
REQ-030 Minimum read latency SHALL be: Read sampled at edge N, mem_req high from cycle N+1, ack at N+1, MDR valid and done high in cycle N+2.
REQ-031 MARin and MDRin SHALL be honoured only in IDLE.
REQ-032 If MDRin and Read/Write coincide in IDLE, the bus value SHALL load first and the access SHALL use it (write of the new value; a read overwrites it).
REQ-033 Read or Write while busy=1 SHALL be ignored, not queued.
REQ-034 mem_ack outside REQ SHALL be ignored.
REQ-035 mem_addr and mem_wdata SHALL be stable for the whole REQ state.

Reset
REQ-036 With reset=1 at a rising edge: state=IDLE, MAR=0, MDR=0, counter=0; mem_req, mem_we, busy, done and err SHALL all be 0.
REQ-037 Reset SHALL take precedence over every other input, including an access in progress (mid-REQ reset aborts without a done pulse).

Structure
REQ-038 State encodings and default ADDR_W/TIMEOUT SHALL live in the shared CPU package with other datapath constants.
REQ-039 MAR and MDR SHALL be instances of the codebase's existing 32-bit register-with-enable sub-module; the FSM and counter SHALL be local.

Verification
REQ-040 Reset, then MARin with bus=0x0000_0042 and Read with mem_ack a cycle later (rdata=0xDEAD_BEEF) -> mem_addr=0x042, BusMuxIn_MDR=0xDEAD_BEEF, done pulses once.
REQ-041 MDRin with bus=0x1234_5678, Write, ack after 3 cycles -> mem_we=1 for 4 cycles, mem_wdata=0x1234_5678, done pulses once.
REQ-042 Read with no ack -> mem_req high for 15 cycles, then err=1 and MDR unchanged; next Read clears err.
REQ-043 Read=Write=1 in IDLE -> mem_we=0; extra Read/MARin/MDRin pulses during REQ -> no effect on MAR/MDR or the access count.
REQ-044 Ack arriving on cycle 15 -> done, not err.
REQ-045 reset asserted mid-REQ -> all outputs 0 the next cycle, no done pulse.

Source files
------------

// File: rtl/mem_bus_interface_pkg.sv
// Shared CPU datapath constants and the memory-bus FSM encoding.
package mem_bus_interface_pkg;

    localparam int DATA_W      = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } busState_e;

    function automatic logic isBusy(input busState_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/mem_bus_interface_if.sv
// Memory-side request/ack bus between the MAR/MDR block and the memory.
interface mem_bus_interface_if
    import mem_bus_interface_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_bus_interface_reg32.sv
// 32-bit register with load enable and synchronous active-high clear.
module mem_bus_interface_reg32
    import mem_bus_interface_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Storage flop: clear on reset, load when enabled, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= {DATA_W{1'b0}};
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_bus_interface.sv
// MAR/MDR memory access block: one read or write at a time, acked by memory,
// aborted with a sticky error flag if no ack arrives within TIMEOUT cycles.
module mem_bus_interface
    import mem_bus_interface_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   BusMuxOut,
    input  logic                MARin,
    input  logic                MDRin,
    input  logic                Read,
    input  logic                Write,
    mem_bus_interface_if.master memBus,
    output logic [DATA_W-1:0]   BusMuxIn_MDR,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    busState_e          curState_r, nextState_s;
    logic [CNT_W-1:0]   tmoCount_r;
    logic               writeOp_r;
    logic               start_s, startWrite_s, ack_s;
    logic               marLoad_s, mdrLoad_s;
    logic [DATA_W-1:0]  mdrD_s, marQ_s, mdrQ_s;
    logic               memReq_r, memWe_r, busy_r, done_r, err_r;
    logic               unusedMarBits_s;

    assign ack_s = memBus.mem_ack;

    // Next-state decode; Read outranks Write when both start together.
    always_comb begin
        nextState_s  = curState_r;
        start_s      = 1'b0;
        startWrite_s = 1'b0;
        case (curState_r)
            ST_IDLE: begin
                if (Read || Write) begin
                    nextState_s  = ST_REQ;
                    start_s      = 1'b1;
                    startWrite_s = ~Read;
                end else begin
                    nextState_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    nextState_s = ST_DONE;
                end else if (tmoCount_r == CNT_LAST) begin
                    nextState_s = ST_ERR;
                end else begin
                    nextState_s = ST_REQ;
                end
            end
            ST_DONE: nextState_s = ST_IDLE;
            ST_ERR:  nextState_s = ST_IDLE;
            default: nextState_s = ST_IDLE;
        endcase
    end

    // MAR/MDR load control: bus loads only in IDLE, read data only on ack.
    always_comb begin
        marLoad_s = (curState_r == ST_IDLE) && MARin;
        mdrLoad_s = 1'b0;
        mdrD_s    = BusMuxOut;
        if (curState_r == ST_IDLE) begin
            mdrLoad_s = MDRin;
            mdrD_s    = BusMuxOut;
        end else if (curState_r == ST_REQ) begin
            mdrLoad_s = ack_s && !writeOp_r;
            mdrD_s    = memBus.mem_rdata;
        end else begin
            mdrLoad_s = 1'b0;
            mdrD_s    = BusMuxOut;
        end
    end

    // State, timeout counter and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            curState_r <= ST_IDLE;
            tmoCount_r <= {CNT_W{1'b0}};
            writeOp_r  <= 1'b0;
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            curState_r <= nextState_s;
            if (start_s) begin
                tmoCount_r <= {CNT_W{1'b0}};
                writeOp_r  <= startWrite_s;
            end else if ((curState_r == ST_REQ) && !ack_s) begin
                tmoCount_r <= tmoCount_r + CNT_W'(1);
            end
            memReq_r <= (nextState_s == ST_REQ);
            memWe_r  <= (nextState_s == ST_REQ) && (start_s ? startWrite_s : writeOp_r);
            busy_r   <= isBusy(nextState_s);
            done_r   <= (nextState_s == ST_DONE);
            if (start_s) begin
                err_r <= 1'b0;
            end else if (nextState_s == ST_ERR) begin
                err_r <= 1'b1;
            end
        end
    end

    mem_bus_interface_reg32 u_mar (
        .clock  (clock),
        .reset  (reset),
        .enable (marLoad_s),
        .d      (BusMuxOut),
        .q      (marQ_s)
    );

    mem_bus_interface_reg32 u_mdr (
        .clock  (clock),
        .reset  (reset),
        .enable (mdrLoad_s),
        .d      (mdrD_s),
        .q      (mdrQ_s)
    );

    // Only the low ADDR_W bits of MAR address the memory.
    assign unusedMarBits_s  = ^marQ_s[DATA_W-1:ADDR_W];

    assign memBus.mem_addr  = marQ_s[ADDR_W-1:0];
    assign memBus.mem_wdata = mdrQ_s;
    assign memBus.mem_req   = memReq_r;
    assign memBus.mem_we    = memWe_r;
    assign BusMuxIn_MDR     = mdrQ_s;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface: stimulus queues expected completions,
// a negedge monitor pops and compares on every done pulse or err rising edge.
module tb_mem_bus_interface;

    typedef struct {
        bit          isErr;
        logic [31:0] mdr;
        logic [31:0] addr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] BusMuxOut = 32'h0;
    logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0] BusMuxIn_MDR;
    logic        busy, done, err;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   events = 0;
    int   cnt;
    exp_t expQ[$];

    mem_bus_interface_if #(.ADDR_W(9)) bus ();

    mem_bus_interface #(.ADDR_W(9), .TIMEOUT(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .BusMuxOut    (BusMuxOut),
        .MARin        (MARin),
        .MDRin        (MDRin),
        .Read         (Read),
        .Write        (Write),
        .memBus       (bus),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input bit isErr, input logic [31:0] mdr, input logic [31:0] addr);
        exp_t e;
        e.isErr = isErr;
        e.mdr   = mdr;
        e.addr  = addr;
        expQ.push_back(e);
    endtask

    // Monitor: consumes one expected entry per completion event.
    initial begin : monitor
        logic errPrev;
        exp_t e;
        errPrev = 1'b0;
        forever begin
            @(negedge clock);
            if (done === 1'b1 || (err === 1'b1 && errPrev !== 1'b1)) begin
                events++;
                check("event_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    check("event_kind", {31'd0, err === 1'b1 && done !== 1'b1}, {31'd0, e.isErr});
                    check("event_mdr", BusMuxIn_MDR, e.mdr);
                    check("event_addr", 32'(bus.mem_addr), e.addr);
                end
            end
            errPrev = err;
        end
    end

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mdr", BusMuxIn_MDR, 32'd0);
        reset = 1'b0;

        // Minimum-latency read
        BusMuxOut = 32'h0000_0042; MARin = 1'b1; tick(); MARin = 1'b0;
        Read = 1'b1; tick(); Read = 1'b0;
        check("rd_req", {31'd0, bus.mem_req}, 32'd1);
        check("rd_we", {31'd0, bus.mem_we}, 32'd0);
        check("rd_addr", 32'(bus.mem_addr), 32'h042);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        pushExp(1'b0, 32'hDEAD_BEEF, 32'h042);
        tick(); bus.mem_ack = 1'b0;
        check("rd_done", {31'd0, done}, 32'd1);
        check("rd_mdr", BusMuxIn_MDR, 32'hDEAD_BEEF);
        tick();
        check("rd_done_once", {31'd0, done}, 32'd0);
        check("rd_idle", {31'd0, busy}, 32'd0);

        // Write of a freshly loaded MDR, ack on the fourth request cycle
        BusMuxOut = 32'h1234_5678; MDRin = 1'b1; Write = 1'b1; tick();
        MDRin = 1'b0; Write = 1'b0; BusMuxOut = 32'h0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_we === 1'b1 && bus.mem_wdata === 32'h1234_5678) cnt++;
            bus.mem_ack = (i == 3);
            if (i == 3) pushExp(1'b0, 32'h1234_5678, 32'h042);
            tick();
        end
        bus.mem_ack = 1'b0;
        check("wr_we_cycles", 32'(cnt), 32'd4);
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_we_after", {31'd0, bus.mem_we}, 32'd0);
        tick();

        // Timeout: 15 request cycles, then sticky err with MDR unchanged
        pushExp(1'b1, 32'h1234_5678, 32'h042);
        Read = 1'b1; tick(); Read = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && bus.mem_req === 1'b1; i++) begin
            cnt++;
            tick();
        end
        check("tmo_req_cycles", 32'(cnt), 32'd15);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd1);
        check("tmo_mdr", BusMuxIn_MDR, 32'h1234_5678);
        tick();
        check("tmo_idle", {31'd0, busy}, 32'd0);
        tick();
        check("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Read+Write start a read and clear err; junk during REQ is ignored
        Read = 1'b1; Write = 1'b1; tick();
        check("rw_err_clr", {31'd0, err}, 32'd0);
        check("rw_we", {31'd0, bus.mem_we}, 32'd0);
        check("rw_req", {31'd0, bus.mem_req}, 32'd1);
        BusMuxOut = 32'hFFFF_FFFF; MARin = 1'b1; MDRin = 1'b1;
        tick(); tick();
        check("junk_addr", 32'(bus.mem_addr), 32'h042);
        check("junk_mdr", bus.mem_wdata, 32'h1234_5678);
        Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0; BusMuxOut = 32'h0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        pushExp(1'b0, 32'hCAFE_F00D, 32'h042);
        tick(); bus.mem_ack = 1'b0;
        check("rw_mdr", BusMuxIn_MDR, 32'hCAFE_F00D);
        tick(); tick();
        check("junk_not_queued", {31'd0, busy}, 32'd0);

        // Ack on the last allowed cycle wins over the timeout
        BusMuxOut = 32'h0000_0100; MARin = 1'b1; tick(); MARin = 1'b0; BusMuxOut = 32'h0;
        pushExp(1'b0, 32'h0BAD_F00D, 32'h100);
        bus.mem_rdata = 32'h0BAD_F00D;
        Read = 1'b1; tick(); Read = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.mem_ack = (i == 14);
            tick();
        end
        bus.mem_ack = 1'b0;
        check("late_done", {31'd0, done}, 32'd1);
        check("late_err", {31'd0, err}, 32'd0);
        check("late_mdr", BusMuxIn_MDR, 32'h0BAD_F00D);
        tick();

        // Reset in the middle of a request aborts silently
        Write = 1'b1; tick(); Write = 1'b0; tick();
        check("mid_req", {31'd0, bus.mem_req}, 32'd1);
        reset = 1'b1; tick();
        check("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_mdr", BusMuxIn_MDR, 32'd0);
        reset = 1'b0; bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        tick(); tick();

        check("queue_drained", 32'(expQ.size()), 32'd0);
        check("event_count", 32'(events), 32'd5);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
